// File: rtl/sram_oq_scheduler_if.sv
// SRAM word-command channel between the output-queue scheduler (master)
// and the SRAM controller (slave).
interface sram_oq_scheduler_if #(
  parameter int QUEUE_ID_WIDTH = 3,
  parameter int MEM_ADDR_WIDTH = 19
);
  logic                      valid;
  logic                      we;
  logic [MEM_ADDR_WIDTH-1:0] addr;
  logic [QUEUE_ID_WIDTH-1:0] qid;
  logic                      ready;

  modport master (output valid, we, addr, qid, input ready);
  modport slave  (input valid, we, addr, qid, output ready);
endinterface

// File: rtl/sram_oq_scheduler.sv
// Arbitrates the single SRAM command port between input writes and round-robin
// output reads, maintaining a circular region, pointers and occupancy per queue.
module sram_oq_scheduler #(
  parameter int NUM_QUEUES     = 5,
  parameter int QUEUE_ID_WIDTH = 3,
  parameter int MEM_ADDR_WIDTH = 19,
  parameter int QUEUE_SIZE     = 104857
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_req,
  input  logic [QUEUE_ID_WIDTH-1:0] wr_qid,
  output logic                      wr_ack,
  output logic [MEM_ADDR_WIDTH-1:0] wr_free,
  output logic                      wr_bad_qid,
  input  logic [NUM_QUEUES-1:0]     rd_port_ready,
  sram_oq_scheduler_if.master       mem_cmd,
  output logic [NUM_QUEUES-1:0]     q_empty,
  output logic [NUM_QUEUES-1:0]     q_full
);

  localparam logic [MEM_ADDR_WIDTH-1:0] QSIZE    = MEM_ADDR_WIDTH'(QUEUE_SIZE);
  localparam logic [MEM_ADDR_WIDTH-1:0] ONE      = MEM_ADDR_WIDTH'(1);
  localparam logic [QUEUE_ID_WIDTH-1:0] LAST_QID = QUEUE_ID_WIDTH'(NUM_QUEUES - 1);
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  logic [MEM_ADDR_WIDTH-1:0] wr_ptr_reg    [NUM_QUEUES];
  logic [MEM_ADDR_WIDTH-1:0] rd_ptr_reg    [NUM_QUEUES];
  logic [MEM_ADDR_WIDTH-1:0] count_reg     [NUM_QUEUES];
  logic [MEM_ADDR_WIDTH-1:0] wr_ptr_next   [NUM_QUEUES];
  logic [MEM_ADDR_WIDTH-1:0] rd_ptr_next   [NUM_QUEUES];
  logic [MEM_ADDR_WIDTH-1:0] count_next    [NUM_QUEUES];
  logic [MEM_ADDR_WIDTH-1:0] base_addr     [NUM_QUEUES];
  logic [NUM_QUEUES-1:0]     q_empty_reg, q_full_reg, empty_next, full_next;
  logic [NUM_QUEUES-1:0]     rd_cand, wr_hit, rd_hit;

  logic                      cmd_valid_reg, cmd_we_reg;
  logic [MEM_ADDR_WIDTH-1:0] cmd_addr_reg;
  logic [QUEUE_ID_WIDTH-1:0] cmd_qid_reg;
  logic [QUEUE_ID_WIDTH-1:0] rr_ptr_reg;
  logic                      last_op_reg;

  logic                      slot_free, wr_valid_qid, wr_cand, rd_any, do_write, do_read;
  logic [QUEUE_ID_WIDTH-1:0] wr_idx, rd_qid, scan_idx;
  int                        scan_pos;

  function automatic logic [MEM_ADDR_WIDTH-1:0] next_off(input logic [MEM_ADDR_WIDTH-1:0] p);
    return (p == QSIZE - ONE) ? '0 : p + ONE;
  endfunction

  assign slot_free    = !cmd_valid_reg || mem_cmd.ready;
  assign wr_valid_qid = (wr_qid <= LAST_QID);
  // Invalid ids are steered to queue 0 for indexing only; wr_cand masks them out.
  assign wr_idx       = wr_valid_qid ? wr_qid : '0;
  assign wr_cand      = wr_req && wr_valid_qid && !q_full_reg[wr_idx];
  assign wr_bad_qid   = wr_req && !wr_valid_qid;
  assign wr_free      = wr_valid_qid ? (QSIZE - count_reg[wr_idx]) : '0;

  always_comb begin
    rd_any   = 1'b0;
    rd_qid   = '0;
    scan_pos = 0;
    scan_idx = '0;
    for (int i = 1; i <= NUM_QUEUES; i++) begin
      scan_pos = int'(rr_ptr_reg) + i;
      if (scan_pos >= NUM_QUEUES) scan_pos = scan_pos - NUM_QUEUES;
      scan_idx = QUEUE_ID_WIDTH'(scan_pos);
      if (!rd_any && rd_cand[scan_idx]) begin
        rd_any = 1'b1;
        rd_qid = scan_idx;
      end
    end
  end

  // On a conflict the direction opposite to the last issued one wins.
  assign do_write = slot_free && wr_cand && (!rd_any || last_op_reg == OP_READ);
  assign do_read  = slot_free && rd_any && !do_write;
  assign wr_ack   = do_write;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_QUEUES; gi++) begin : g_queue
      assign base_addr[gi]   = MEM_ADDR_WIDTH'(gi * QUEUE_SIZE);
      assign rd_cand[gi]     = !q_empty_reg[gi] && rd_port_ready[gi];
      assign wr_hit[gi]      = do_write && (wr_idx == QUEUE_ID_WIDTH'(gi));
      assign rd_hit[gi]      = do_read && (rd_qid == QUEUE_ID_WIDTH'(gi));
      assign wr_ptr_next[gi] = wr_hit[gi] ? next_off(wr_ptr_reg[gi]) : wr_ptr_reg[gi];
      assign rd_ptr_next[gi] = rd_hit[gi] ? next_off(rd_ptr_reg[gi]) : rd_ptr_reg[gi];
      assign count_next[gi]  = wr_hit[gi] ? count_reg[gi] + ONE :
                               rd_hit[gi] ? count_reg[gi] - ONE : count_reg[gi];
      assign empty_next[gi]  = (count_next[gi] == '0);
      assign full_next[gi]   = (count_next[gi] == QSIZE);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid_reg <= 1'b0;
      cmd_we_reg    <= 1'b0;
      cmd_addr_reg  <= '0;
      cmd_qid_reg   <= '0;
      rr_ptr_reg    <= LAST_QID;
      last_op_reg   <= OP_READ;
      wr_ptr_reg    <= '{default: '0};
      rd_ptr_reg    <= '{default: '0};
      count_reg     <= '{default: '0};
      q_empty_reg   <= '1;
      q_full_reg    <= '0;
    end else begin
      if (slot_free) begin
        cmd_valid_reg <= do_write || do_read;
        if (do_write) begin
          cmd_we_reg   <= 1'b1;
          cmd_addr_reg <= base_addr[wr_idx] + wr_ptr_reg[wr_idx];
          cmd_qid_reg  <= wr_idx;
          last_op_reg  <= OP_WRITE;
        end else if (do_read) begin
          cmd_we_reg   <= 1'b0;
          cmd_addr_reg <= base_addr[rd_qid] + rd_ptr_reg[rd_qid];
          cmd_qid_reg  <= rd_qid;
          last_op_reg  <= OP_READ;
          rr_ptr_reg   <= rd_qid;
        end
      end
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      count_reg   <= count_next;
      q_empty_reg <= empty_next;
      q_full_reg  <= full_next;
    end
  end

  assign mem_cmd.valid = cmd_valid_reg;
  assign mem_cmd.we    = cmd_we_reg;
  assign mem_cmd.addr  = cmd_addr_reg;
  assign mem_cmd.qid   = cmd_qid_reg;
  assign q_empty       = q_empty_reg;
  assign q_full        = q_full_reg;

endmodule
